accl_pair_scheduler: RTL
========================

Name: accl_pair_scheduler

Overview:
Sequences the acceleration/velocity phase of one n-body timestep. It walks every ordered (i,j) body pair with i≠j and drives the i-port and j-port read addresses of the position/mass RAMs. It tags each pair with valid/first/last sideband through the RAM and getAccl latency. It emits accumulator-clear and velocity-writeback strobes per body i, then pulses done so the top-level FSM can enter the position-update phase.

Parameters:
BODIES, 512, maximum body count
BODY_ADDR_WIDTH, $clog2(BODIES), body index width
RAM_LATENCY, 1, cycles from read address to RAM q
ACCL_LATENCY, 58, cycles from getAccl input to ax/ay valid

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin one pass; honoured only in IDLE
abort  in  1  go dropped by software; synchronous flush to IDLE
num_bodies  in  BODY_ADDR_WIDTH+1  body count N, sampled on accepted start
busy  out  1  high in ISSUE, DRAIN or DONE
done  out  1  one-cycle pulse, pass complete
rd_i  out  BODY_ADDR_WIDTH  i-body read address (x,y RAM port a)
rd_j  out  BODY_ADDR_WIDTH  j-body read address (x,y port b, m)
issue_valid  out  1  rd_i/rd_j hold a real pair this cycle
accl_in_valid  out  1  RAM q presented to getAccl is a real pair
res_valid  out  1  getAccl ax/ay valid this cycle
res_i  out  BODY_ADDR_WIDTH  i index of the current result
res_first  out  1  first result for res_i (accumulator load, not add)
res_last  out  1  last result for res_i
vel_wr_en  out  1  res_valid & res_last; write updated vx/vy
vel_wr_addr  out  BODY_ADDR_WIDTH  equals res_i

Behaviour:
- Reset: state IDLE. Every output, counter and tag shift-register bit is 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch Nl = min(num_bodies, BODIES).
  - If Nl<2, go to DONE with no issues.
  - Otherwise go to ISSUE with i=0 and j=1.
- ISSUE: one pair per cycle, with no bubbles.
  - issue_valid=1, rd_i=i, rd_j=j.
  - Next j is j+1, skipping i. If j+1==i, use j+2.
  - When next j would reach Nl, set i=i+1 and j=0. If the new i is 0, use j=1 instead.
  - After the pair (Nl-1, Nl-2) is issued, go to DRAIN.
  - Total issues per pass = Nl*(Nl-1).
- Tagging at issue:
  - first = (j is the lowest index ≠ i), i.e. j==0, or j==1 when i==0.
  - last = (j is the highest index ≠ i), i.e. j==Nl-1, or j==Nl-2 when i==Nl-1.
- Tag pipeline: {valid, i, first, last} passes through a delay line.
  - accl_in_valid = issue_valid delayed RAM_LATENCY.
  - res_valid/res_i/res_first/res_last = issue tags delayed L = RAM_LATENCY + ACCL_LATENCY.
  - Outputs are 0 when not valid.
- DRAIN: stays until the in-flight count is 0.
  - In-flight counter: +1 on issue, −1 on res_valid; both in the same cycle leaves it unchanged.
  - Next cycle goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing: if start is accepted at cycle k with Nl≥2:
  - pairs issue at cycles k+1 … k+Nl(Nl−1);
  - results appear L cycles later;
  - done is at k+Nl(Nl−1)+L+1.
- Nl<2: done at k+1. No issue_valid, res_valid or vel_wr_en is ever raised.
- start while busy: ignored. num_bodies is not resampled.
- abort in any state: the next cycle is IDLE, and all counters and delay-line valids are cleared. In-flight results are dropped, so no res_valid/vel_wr_en follows. done is not pulsed.
- abort and start in the same cycle: abort wins.
- Async rst mid-pass: immediate return to reset values.
- vel_wr_en may coincide with res_first of the next i only if L=0. L≥1 is required, and a parameter check errors if it is not.

Test Plan:
- RAM_LATENCY=1, ACCL_LATENCY=4, N=3, start at cycle 0:
  - issue pairs (0,1)(0,2)(1,0)(1,2)(2,0)(2,1) at cycles 1–6;
  - res_valid at cycles 6–11, with res_first at 6, 8, 10;
  - vel_wr_en at 7 (addr 0), 9 (addr 1), 11 (addr 2);
  - done at 12.
- N=1 and N=0, start at cycle 0 -> done at cycle 1, zero issue_valid/res_valid, busy high only in cycle 1.
- N=3, abort at cycle 4 -> IDLE at cycle 5; no res_valid, vel_wr_en or done thereafter; a new start at 8 repeats the full N=3 sequence shifted by 8.
- N=3, start re-pulsed at cycle 3 and num_bodies changed to 5 -> ignored; sequence and done cycle are identical to the first scenario.
- N=600 (>BODIES=512), default latencies -> clamped to 512; 261632 issues; 512 vel_wr_en with addrs 0…511 in order; done at 261632+59+1 cycles after start.
- rst asserted asynchronously mid-ISSUE -> all outputs 0 without a clock edge; after release, IDLE and an idle-start behaves normally.

Source files
------------

// File: rtl/accl_pair_scheduler.sv
// accl_pair_scheduler: walks ordered (i,j) body pairs for one n-body accel pass.
// Ports: clk/rst, start/abort/num_bodies in; busy/done, rd_i/rd_j/issue_valid,
// accl_in_valid, res_valid/res_i/res_first/res_last, vel_wr_en/vel_wr_addr out.
module accl_pair_scheduler #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int RAM_LATENCY     = 1,
  parameter int ACCL_LATENCY    = 58
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  output logic                       busy,
  output logic                       done,
  output logic [BODY_ADDR_WIDTH-1:0] rd_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_j,
  output logic                       issue_valid,
  output logic                       accl_in_valid,
  output logic                       res_valid,
  output logic [BODY_ADDR_WIDTH-1:0] res_i,
  output logic                       res_first,
  output logic                       res_last,
  output logic                       vel_wr_en,
  output logic [BODY_ADDR_WIDTH-1:0] vel_wr_addr
);

  localparam int AW = BODY_ADDR_WIDTH;
  localparam int NW = AW + 1;
  localparam int L  = RAM_LATENCY + ACCL_LATENCY;
  localparam int CW = $clog2(L + 1) + 1;
  localparam logic [NW-1:0] BMAX = NW'(BODIES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (L < 1) begin : g_bad_lat
    $error("RAM_LATENCY + ACCL_LATENCY must be at least 1");
  end

  logic [1:0]    state;
  logic [NW-1:0] nl;
  logic [AW-1:0] ci;
  logic [AW-1:0] cj;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic [L-1:0]  dv;
  logic [L-1:0]  df;
  logic [L-1:0]  dl;
  logic [AW-1:0] di [L];

  logic [NW-1:0] nl_in;
  logic [NW-1:0] i_w;
  logic [NW-1:0] j_w;
  logic [NW-1:0] j1;
  logic [NW-1:0] jn;
  logic [AW-1:0] i_n;
  logic          wrap;
  logic          last_pair;
  logic          first_t;
  logic          last_t;

  assign nl_in = (num_bodies > BMAX) ? BMAX : num_bodies;

  assign i_w = {1'b0, ci};
  assign j_w = {1'b0, cj};
  assign j1  = j_w + NW'(1);
  // j never equals i: step over the diagonal
  assign jn  = (j1 == i_w) ? j_w + NW'(2) : j1;
  assign wrap = (jn >= nl);
  assign i_n  = ci + 1'b1;

  assign last_pair = (i_w == nl - NW'(1)) &&
                     (j_w == nl - NW'(2));
  assign first_t = (j_w == '0) ||
                   ((i_w == '0) && (j_w == NW'(1)));
  assign last_t  = (j_w == nl - NW'(1)) || last_pair;

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign issue_valid = (state == S_ISSUE);
  assign rd_i        = issue_valid ? ci : '0;
  assign rd_j        = issue_valid ? cj : '0;

  always_comb begin
    cnt_n = cnt;
    case ({issue_valid, res_valid})
      2'b10:   cnt_n = cnt + 1'b1;
      2'b01:   cnt_n = cnt - 1'b1;
      default: cnt_n = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      nl    <= '0;
      ci    <= '0;
      cj    <= '0;
      cnt   <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      nl    <= '0;
      ci    <= '0;
      cj    <= '0;
      cnt   <= '0;
    end else begin
      cnt <= cnt_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            nl    <= nl_in;
            ci    <= '0;
            cj    <= AW'(1);
            state <= (nl_in < NW'(2)) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last_pair) begin
            ci    <= '0;
            cj    <= '0;
            state <= S_DRAIN;
          end else if (wrap) begin
            ci <= i_n;
            cj <= (i_n == '0) ? AW'(1) : '0;
          end else begin
            cj <= jn[AW-1:0];
          end
        end
        // leave as the final result retires, so done
        // lands the cycle after it
        S_DRAIN: begin
          if (cnt_n == '0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // tag delay line; payload is zeroed when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv <= '0;
      df <= '0;
      dl <= '0;
      for (int k = 0; k < L; k++) di[k] <= '0;
    end else if (abort) begin
      dv <= '0;
      df <= '0;
      dl <= '0;
      for (int k = 0; k < L; k++) di[k] <= '0;
    end else begin
      dv[0] <= issue_valid;
      df[0] <= issue_valid & first_t;
      dl[0] <= issue_valid & last_t;
      di[0] <= rd_i;
      for (int k = 1; k < L; k++) begin
        dv[k] <= dv[k-1];
        df[k] <= df[k-1];
        dl[k] <= dl[k-1];
        di[k] <= di[k-1];
      end
    end
  end

  if (RAM_LATENCY == 0) begin : g_acc0
    assign accl_in_valid = issue_valid;
  end else begin : g_acc
    assign accl_in_valid = dv[RAM_LATENCY-1];
  end

  assign res_valid   = dv[L-1];
  assign res_first   = df[L-1];
  assign res_last    = dl[L-1];
  assign res_i       = di[L-1];
  assign vel_wr_en   = res_valid & res_last;
  assign vel_wr_addr = res_i;

endmodule
